fetch_decode_queue: RTL and testbench

//  - Decoupling FIFO between instruction fetch and decode. Captures {PC, instruction}

---
 rtl/fetch_decode_queue.sv | 83 ++++++++
 tb/tb_fetch_decode_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order {PC, instruction} FIFO between fetch and decode with flush.
// Optional predecode of control-flow opcodes is enabled by FETCH_DECODE_QUEUE_PREDECODE_EN.
module fetch_decode_queue #(
    parameter int DEPTH   = 2,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
`ifdef FETCH_DECODE_QUEUE_PREDECODE_EN
    output logic                     out_is_ctrl,
`endif
    output logic [$clog2(DEPTH):0]   out_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic [PC_W-1:0]    pc_mem [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               push, pop;

    // Flush wins over any handshake offered in the same cycle
    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];
    assign out_count = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

`ifdef FETCH_DECODE_QUEUE_PREDECODE_EN
    logic [DEPTH-1:0] ctrl_mem;
    logic             in_is_ctrl;

    // Branch, JAL and JALR opcodes
    assign in_is_ctrl  = in_instr[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
    assign out_is_ctrl = ctrl_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ctrl_mem <= '0;
        else if (push) ctrl_mem[wr_ptr] <= in_is_ctrl;
    end
`endif
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: scoreboard bench with randomized fetch/decode traffic and a queue model.
module tb_fetch_decode_queue;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 0;
    logic          reset_n = 0;
    logic          in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
    logic [63:0]   in_pc = '0, out_pc;
    logic [31:0]   in_instr = '0, out_instr;
    logic [CW-1:0] out_count;
    logic          is_ctrl;

    fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(64), .INSTR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
`ifdef FETCH_DECODE_QUEUE_PREDECODE_EN
        .out_is_ctrl(is_ctrl),
`endif
        .out_count(out_count)
    );
`ifndef FETCH_DECODE_QUEUE_PREDECODE_EN
    assign is_ctrl = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        ctrl;
    } entry_t;

    entry_t exp_q[$];
    int     mcount = 0;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ctrl_of(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return op == 7'h63 || op == 7'h6F || op == 7'h67;
    endfunction

    // Issues one cycle of stimulus, then advances the model past the edge.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        entry_t e;
        logic push, pop;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
        push = v && mcount < DEPTH && !fl;
        pop  = rdy && mcount > 0 && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (push) begin
                e.pc = pc; e.instr = ins; e.ctrl = ctrl_of(ins);
                exp_q.push_back(e);
            end
            mcount = mcount + int'(push) - int'(pop);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_pc"}, out_pc, 64'd0);
        chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_out_count"}, 64'(out_count), 64'd0);
    endtask

    // Monitor: checks status against the model and pops the scoreboard on every handshake.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("out_valid", 64'(out_valid), 64'(mcount != 0));
                chk("in_ready", 64'(in_ready), 64'(mcount < DEPTH));
                chk("out_count", 64'(out_count), 64'(mcount));
                if (out_valid && out_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL pop_empty: got handshake pc %0h expected no entry", out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_instr", 64'(out_instr), 64'(e.instr));
`ifdef FETCH_DECODE_QUEUE_PREDECODE_EN
                        chk("out_is_ctrl", 64'(is_ctrl), 64'(e.ctrl));
`endif
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 4)
            0: r[6:0] = 7'h63;
            1: r[6:0] = 7'h6F;
            2: r[6:0] = 7'h67;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic        hv;
        logic [63:0] hpc, next_pc;
        logic [31:0] hins;
        logic        fl, rdy, acc;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1;

        // Single push becomes visible the cycle after the edge
        cycle(1, 64'h0, 32'h00500093, 0, 0);
        cycle(0, 64'h0, 32'h0, 0, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        cycle(0, 64'h0, 32'h0, 0, 0);

        // Fill, hold the third word, pop on full then accept it
        cycle(1, 64'h0, 32'h13, 0, 0);
        cycle(1, 64'h4, 32'h113, 0, 0);
        cycle(1, 64'h8, 32'h213, 0, 0);
        cycle(1, 64'h8, 32'h213, 1, 0);
        cycle(1, 64'h8, 32'h213, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 64'h0, 32'h0, 1, 0);

        // Steady push+pop with one entry in flight
        cycle(1, 64'h0, 32'h1000, 0, 0);
        for (int i = 1; i <= 8; i++) cycle(1, 64'(4 * i), 32'(32'h1000 + i), 1, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        cycle(0, 64'h0, 32'h0, 0, 0);

        // Flush with both handshakes offered
        cycle(1, 64'h40, 32'h2000, 0, 0);
        cycle(1, 64'h44, 32'h2004, 0, 0);
        cycle(1, 64'h48, 32'h2008, 1, 1);
        cycle(0, 64'h0, 32'h0, 1, 0);

        // Predecode bit follows its entry
        cycle(1, 64'h100, 32'hFE000EE3, 0, 0);
        cycle(1, 64'h104, 32'h00000013, 0, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        cycle(0, 64'h0, 32'h0, 0, 0);

        // Random traffic; a held word stays stable until accepted
        hv = 0; hpc = '0; hins = '0; next_pc = 64'h8000_0000;
        for (int n = 0; n < 1500; n++) begin
            if (!hv && $urandom % 4 != 0) begin
                hv = 1; hpc = next_pc; next_pc += 4; hins = rand_instr();
            end
            fl  = $urandom % 20 == 0;
            rdy = $urandom % 3 != 0;
            acc = hv && mcount < DEPTH && !fl;
            cycle(hv, hpc, hins, rdy, fl);
            if (acc) hv = 0;
            if (fl) begin
                hv = 0;
                next_pc = {32'h0, $urandom} & ~64'h3;
            end
        end

        // Asynchronous reset between edges with traffic in flight
        cycle(1, 64'h500, 32'h3000, 0, 0);
        cycle(1, 64'h504, 32'h3004, 0, 0);
        in_valid = 1; out_ready = 1;
        @(negedge clk);
        #2 reset_n = 0;
        #1 check_reset_outputs("async_reset");
        in_valid = 0; out_ready = 0;
        @(posedge clk);
        #1;
        mcount = 0;
        exp_q.delete();
        reset_n = 1;
        cycle(1, 64'h600, 32'h4000, 0, 0);
        cycle(0, 64'h0, 32'h0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 64'h0, 32'h0, 1, 0);
        @(negedge clk);
        chk("drain_left", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
